// File: rtl/spi_slave_core.sv
// SPI Mode 0 slave endpoint (CPOL=0, CPHA=0, MSB first).
// The SPI pins are oversampled in the I_CLK domain. Received bits are
// assembled into words. Transmit words come from a single-entry holding
// register, or from TX_IDLE_BYTE when the holding register is empty.
module spi_slave_core #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    SYNC_STAGES  = 2,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE_BYTE = 8'hFF
) (
    input  logic                  I_CLK,
    input  logic                  I_RESETN,
    input  logic                  SCLK_SLAVE,
    input  logic                  SS_N_SLAVE,
    input  logic                  MOSI_SLAVE,
    output logic                  MISO_SLAVE,
    output logic                  MISO_OE,
    input  logic                  I_TX_EN,
    input  logic [DATA_WIDTH-1:0] I_TX_DATA,
    output logic                  O_TX_READY,
    output logic [DATA_WIDTH-1:0] O_RX_DATA,
    output logic                  O_RX_VALID,
    output logic                  O_FRAME_ERR,
    output logic                  O_BUSY
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Synchronizer chains and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   sclk_prev_q;
    logic                   ss_prev_q;
    logic                   armed_q;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise;

    // FSM and datapath state
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] holding_q, holding_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  reload_q, reload_d;
    logic                  oe_q, oe_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;

    logic                  consume;
    logic [DATA_WIDTH-1:0] load_word;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // A frame may only start once SS_N has genuinely been seen high after
    // reset; fill_q marks when the chain output holds a real pin sample
    // rather than its reset value, so SS_N held low through reset is ignored.
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_fall   = armed_q & ss_prev_q & ~ss_s;
    assign ss_rise   = ss_s & ~ss_prev_q;

    assign load_word = hold_full_q ? holding_q : TX_IDLE_BYTE;

    // Synchronize pins into I_CLK and keep one cycle of history for edges
    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK_SLAVE};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_N_SLAVE};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI_SLAVE};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & ss_s);
        end
    end

    // State register for the FSM and its shift/holding datapath
    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            state_q     <= ST_IDLE;
            holding_q   <= '0;
            hold_full_q <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            reload_q    <= 1'b0;
            oe_q        <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            holding_q   <= holding_d;
            hold_full_q <= hold_full_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            reload_q    <= reload_d;
            oe_q        <= oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: frame control, bit shifting and TX holding register
    always_comb begin
        state_d     = state_q;
        holding_d   = holding_q;
        hold_full_d = hold_full_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        reload_d    = reload_q;
        oe_d        = oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        consume     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d    = ST_SHIFT;
                    tx_shift_d = load_word;
                    consume    = 1'b1;
                    bit_cnt_d  = '0;
                    reload_d   = 1'b0;
                    oe_d       = 1'b1;
                end
            end
            ST_SHIFT: begin
                // Sampling edge is handled before a coincident SS_N rise so a
                // word completed on that edge is still delivered.
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        reload_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                // After a word boundary the next falling edge presents a fresh
                // word instead of shifting, allowing back-to-back words.
                if (sclk_fall) begin
                    if (reload_q) begin
                        tx_shift_d = load_word;
                        consume    = 1'b1;
                        reload_d   = 1'b0;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    oe_d        = 1'b0;
                    frame_err_d = (bit_cnt_d != '0);
                    bit_cnt_d   = '0;
                    reload_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A write in the same cycle as a load refills the register after the
        // old value has been taken; a write to a full register overwrites it.
        if (consume) begin
            hold_full_d = 1'b0;
        end
        if (I_TX_EN) begin
            holding_d   = I_TX_DATA;
            hold_full_d = 1'b1;
        end
    end

    assign MISO_SLAVE  = oe_q & tx_shift_q[DATA_WIDTH-1];
    assign MISO_OE     = oe_q;
    assign O_TX_READY  = ~hold_full_q;
    assign O_RX_DATA   = rx_data_q;
    assign O_RX_VALID  = rx_valid_q;
    assign O_FRAME_ERR = frame_err_q;
    assign O_BUSY      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core acting as an SPI Mode 0 master.
module tb_spi_slave_core;

    localparam int HALF = 8;   // I_CLK cycles per SCLK half period

    logic       I_CLK = 1'b0;
    logic       I_RESETN = 1'b0;
    logic       SCLK_SLAVE = 1'b0;
    logic       SS_N_SLAVE = 1'b1;
    logic       MOSI_SLAVE = 1'b0;
    logic       MISO_SLAVE;
    logic       MISO_OE;
    logic       I_TX_EN = 1'b0;
    logic [7:0] I_TX_DATA = 8'h00;
    logic       O_TX_READY;
    logic [7:0] O_RX_DATA;
    logic       O_RX_VALID;
    logic       O_FRAME_ERR;
    logic       O_BUSY;

    int checks = 0;
    int failures = 0;

    int         rx_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] rx_log [0:31];

    spi_slave_core #(
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2),
        .TX_IDLE_BYTE(8'hFF)
    ) dut (
        .I_CLK      (I_CLK),
        .I_RESETN   (I_RESETN),
        .SCLK_SLAVE (SCLK_SLAVE),
        .SS_N_SLAVE (SS_N_SLAVE),
        .MOSI_SLAVE (MOSI_SLAVE),
        .MISO_SLAVE (MISO_SLAVE),
        .MISO_OE    (MISO_OE),
        .I_TX_EN    (I_TX_EN),
        .I_TX_DATA  (I_TX_DATA),
        .O_TX_READY (O_TX_READY),
        .O_RX_DATA  (O_RX_DATA),
        .O_RX_VALID (O_RX_VALID),
        .O_FRAME_ERR(O_FRAME_ERR),
        .O_BUSY     (O_BUSY)
    );

    always #5 I_CLK = ~I_CLK;

    // Count strobe cycles; each cycle high is one reported event
    always @(negedge I_CLK) begin
        if (O_RX_VALID) begin
            if (rx_cnt < 32) rx_log[rx_cnt] <= O_RX_DATA;
            rx_cnt <= rx_cnt + 1;
        end
        if (O_FRAME_ERR) err_cnt <= err_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge I_CLK);
        #1;
    endtask

    task automatic tx_write(input logic [7:0] d);
        I_TX_EN = 1'b1;
        I_TX_DATA = d;
        cyc(1);
        I_TX_EN = 1'b0;
    endtask

    // Clock nbits MSB-first; optionally write TX data during bit wr_bit
    task automatic spi_word(input logic [7:0] mosi, input int nbits, input int wr_bit,
                            input logic [7:0] wr_data, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI_SLAVE = mosi[7-i];
            if (i == wr_bit) begin
                tx_write(wr_data);
                cyc(HALF - 1);
            end else begin
                cyc(HALF);
            end
            SCLK_SLAVE = 1'b1;
            miso = {miso[6:0], MISO_SLAVE};
            cyc(HALF);
            SCLK_SLAVE = 1'b0;
        end
    endtask

    task automatic frame_begin();
        SS_N_SLAVE = 1'b0;
        cyc(HALF);
    endtask

    task automatic frame_end();
        cyc(HALF);
        SS_N_SLAVE = 1'b1;
        cyc(HALF + 4);
    endtask

    task automatic test_reset();
        I_RESETN = 1'b0;
        cyc(3);
        checks++; if (MISO_SLAVE !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", MISO_SLAVE); end
        checks++; if (MISO_OE !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", MISO_OE); end
        checks++; if (O_TX_READY !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", O_TX_READY); end
        checks++; if (O_RX_DATA !== 8'h00) begin failures++; $display("FAIL reset_rxdata got=%h exp=00", O_RX_DATA); end
        checks++; if (O_RX_VALID !== 1'b0) begin failures++; $display("FAIL reset_rxvalid got=%b exp=0", O_RX_VALID); end
        checks++; if (O_FRAME_ERR !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", O_FRAME_ERR); end
        checks++; if (O_BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", O_BUSY); end
        I_RESETN = 1'b1;
        cyc(6);
    endtask

    task automatic test_basic();
        logic [7:0] m;
        int rb, eb;
        rb = rx_cnt; eb = err_cnt;
        tx_write(8'hA5);
        checks++; if (O_TX_READY !== 1'b0) begin failures++; $display("FAIL basic_ready_full got=%b exp=0", O_TX_READY); end
        frame_begin();
        checks++; if (O_TX_READY !== 1'b1) begin failures++; $display("FAIL basic_ready_after_load got=%b exp=1", O_TX_READY); end
        checks++; if (O_BUSY !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", O_BUSY); end
        checks++; if (MISO_OE !== 1'b1) begin failures++; $display("FAIL basic_oe got=%b exp=1", MISO_OE); end
        spi_word(8'h3C, 8, -1, 8'h00, m);
        checks++; if (m !== 8'hA5) begin failures++; $display("FAIL basic_miso got=%h exp=a5", m); end
        frame_end();
        checks++; if (rx_cnt - rb !== 1) begin failures++; $display("FAIL basic_rx_count got=%0d exp=1", rx_cnt - rb); end
        checks++; if (rx_log[rb] !== 8'h3C) begin failures++; $display("FAIL basic_rx_word got=%h exp=3c", rx_log[rb]); end
        checks++; if (O_RX_DATA !== 8'h3C) begin failures++; $display("FAIL basic_rxdata_held got=%h exp=3c", O_RX_DATA); end
        checks++; if (err_cnt - eb !== 0) begin failures++; $display("FAIL basic_ferr got=%0d exp=0", err_cnt - eb); end
        checks++; if (MISO_OE !== 1'b0) begin failures++; $display("FAIL basic_oe_end got=%b exp=0", MISO_OE); end
        checks++; if (MISO_SLAVE !== 1'b0) begin failures++; $display("FAIL basic_miso_end got=%b exp=0", MISO_SLAVE); end
        checks++; if (O_BUSY !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", O_BUSY); end
    endtask

    task automatic test_idle_byte();
        logic [7:0] m;
        int rb;
        rb = rx_cnt;
        frame_begin();
        spi_word(8'h00, 8, -1, 8'h00, m);
        frame_end();
        checks++; if (m !== 8'hFF) begin failures++; $display("FAIL idle_miso got=%h exp=ff", m); end
        checks++; if (rx_cnt - rb !== 1) begin failures++; $display("FAIL idle_rx_count got=%0d exp=1", rx_cnt - rb); end
        checks++; if (O_RX_DATA !== 8'h00) begin failures++; $display("FAIL idle_rxdata got=%h exp=00", O_RX_DATA); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m1, m2;
        int rb;
        rb = rx_cnt;
        frame_begin();
        spi_word(8'h01, 8, 3, 8'h5A, m1);
        spi_word(8'h80, 8, -1, 8'h00, m2);
        frame_end();
        checks++; if (m1 !== 8'hFF) begin failures++; $display("FAIL b2b_miso_w1 got=%h exp=ff", m1); end
        checks++; if (m2 !== 8'h5A) begin failures++; $display("FAIL b2b_miso_w2 got=%h exp=5a", m2); end
        checks++; if (rx_cnt - rb !== 2) begin failures++; $display("FAIL b2b_rx_count got=%0d exp=2", rx_cnt - rb); end
        checks++; if (rx_log[rb] !== 8'h01) begin failures++; $display("FAIL b2b_rx_w1 got=%h exp=01", rx_log[rb]); end
        checks++; if (rx_log[rb+1] !== 8'h80) begin failures++; $display("FAIL b2b_rx_w2 got=%h exp=80", rx_log[rb+1]); end
        checks++; if (O_TX_READY !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", O_TX_READY); end
    endtask

    task automatic test_frame_err();
        logic [7:0] m;
        int rb, eb;
        rb = rx_cnt; eb = err_cnt;
        frame_begin();
        spi_word(8'hFF, 5, -1, 8'h00, m);
        frame_end();
        checks++; if (err_cnt - eb !== 1) begin failures++; $display("FAIL ferr_pulse got=%0d exp=1", err_cnt - eb); end
        checks++; if (rx_cnt - rb !== 0) begin failures++; $display("FAIL ferr_no_valid got=%0d exp=0", rx_cnt - rb); end
        checks++; if (O_RX_DATA !== 8'h80) begin failures++; $display("FAIL ferr_rxdata_kept got=%h exp=80", O_RX_DATA); end
        frame_begin();
        spi_word(8'hC3, 8, -1, 8'h00, m);
        frame_end();
        checks++; if (rx_cnt - rb !== 1) begin failures++; $display("FAIL ferr_next_count got=%0d exp=1", rx_cnt - rb); end
        checks++; if (O_RX_DATA !== 8'hC3) begin failures++; $display("FAIL ferr_next_rxdata got=%h exp=c3", O_RX_DATA); end
        checks++; if (err_cnt - eb !== 1) begin failures++; $display("FAIL ferr_next_no_err got=%0d exp=1", err_cnt - eb); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] m;
        int rb;
        frame_begin();
        spi_word(8'hAA, 3, -1, 8'h00, m);
        I_RESETN = 1'b0;
        cyc(3);
        checks++; if (O_BUSY !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", O_BUSY); end
        checks++; if (MISO_OE !== 1'b0) begin failures++; $display("FAIL rstmid_oe got=%b exp=0", MISO_OE); end
        checks++; if (O_RX_DATA !== 8'h00) begin failures++; $display("FAIL rstmid_rxdata got=%h exp=00", O_RX_DATA); end
        checks++; if (O_TX_READY !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", O_TX_READY); end
        I_RESETN = 1'b1;
        rb = rx_cnt;
        cyc(20);
        checks++; if (O_BUSY !== 1'b0) begin failures++; $display("FAIL rstmid_no_start got=%b exp=0", O_BUSY); end
        checks++; if (MISO_OE !== 1'b0) begin failures++; $display("FAIL rstmid_oe_idle got=%b exp=0", MISO_OE); end
        spi_word(8'h55, 8, -1, 8'h00, m);
        cyc(HALF);
        checks++; if (rx_cnt - rb !== 0) begin failures++; $display("FAIL rstmid_sclk_ignored got=%0d exp=0", rx_cnt - rb); end
        checks++; if (O_BUSY !== 1'b0) begin failures++; $display("FAIL rstmid_busy_after_sclk got=%b exp=0", O_BUSY); end
        SS_N_SLAVE = 1'b1;
        cyc(HALF + 4);
        frame_begin();
        spi_word(8'h77, 8, -1, 8'h00, m);
        frame_end();
        checks++; if (rx_cnt - rb !== 1) begin failures++; $display("FAIL rstmid_rx_count got=%0d exp=1", rx_cnt - rb); end
        checks++; if (O_RX_DATA !== 8'h77) begin failures++; $display("FAIL rstmid_rxdata_77 got=%h exp=77", O_RX_DATA); end
    endtask

    task automatic test_tx_overwrite();
        logic [7:0] m;
        int rb;
        rb = rx_cnt;
        tx_write(8'h11);
        cyc(2);
        tx_write(8'h22);
        checks++; if (O_TX_READY !== 1'b0) begin failures++; $display("FAIL ovw_ready got=%b exp=0", O_TX_READY); end
        spi_word(8'hFF, 8, -1, 8'h00, m);
        cyc(HALF);
        checks++; if (MISO_OE !== 1'b0) begin failures++; $display("FAIL ovw_idle_oe got=%b exp=0", MISO_OE); end
        checks++; if (MISO_SLAVE !== 1'b0) begin failures++; $display("FAIL ovw_idle_miso got=%b exp=0", MISO_SLAVE); end
        checks++; if (O_BUSY !== 1'b0) begin failures++; $display("FAIL ovw_idle_busy got=%b exp=0", O_BUSY); end
        checks++; if (rx_cnt - rb !== 0) begin failures++; $display("FAIL ovw_idle_rx got=%0d exp=0", rx_cnt - rb); end
        checks++; if (O_TX_READY !== 1'b0) begin failures++; $display("FAIL ovw_idle_ready got=%b exp=0", O_TX_READY); end
        frame_begin();
        spi_word(8'h96, 8, -1, 8'h00, m);
        frame_end();
        checks++; if (m !== 8'h22) begin failures++; $display("FAIL ovw_miso got=%h exp=22", m); end
        checks++; if (O_RX_DATA !== 8'h96) begin failures++; $display("FAIL ovw_rxdata got=%h exp=96", O_RX_DATA); end
        checks++; if (O_TX_READY !== 1'b1) begin failures++; $display("FAIL ovw_ready_end got=%b exp=1", O_TX_READY); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_idle_byte();
        test_back_to_back();
        test_frame_err();
        test_reset_midframe();
        test_tx_overwrite();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
